// File: rtl/param_updown_counter.sv
// Purpose : parametrised up/down counter with modulus, wrap/saturate, variable step,
//           parallel load, prescaled enable and registered overflow/underflow pulses.
// Latency : count/ovf/unf update one clock after the step/load edge; at_max/at_min follow count combinationally.
// Backpress: none; every input is sampled each cycle (priority reset > load > en).
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset (clears count, prescaler, flags)
//   en        count enable, advances the prescaler
//   up_down   1 = up, 0 = down; only looked at on step cycles
//   step      step magnitude, 0..MAX_VAL
//   load      synchronous parallel load of load_val (clamped to MAX_VAL)
//   load_val  value to load
//   count     current count (registered)
//   at_max    count == MAX_VAL
//   at_min    count == 0
//   ovf       one-cycle pulse: an up step crossed MAX_VAL
//   unf       one-cycle pulse: a down step crossed 0
module param_updown_counter #(
   parameter int WIDTH    = 8,
   parameter int MAX_VAL  = 2**WIDTH-1,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_down,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             ovf,
   output logic             unf
);

   // Prescaler needs at least one bit even when PRESCALE == 1 (it then stays at 0).
   localparam int                PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]     PS_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]     PS_ONE  = PW'(1);

   // Arithmetic is carried one bit wider than the count so sums never overflow.
   localparam logic [WIDTH:0]    MAX_X   = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]    MOD_X   = (WIDTH+1)'(MAX_VAL + 1);
   localparam logic [WIDTH-1:0]  MAX_W   = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] r_count;
   logic [PW-1:0]    r_presc;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH:0]   w_cnt_x;
   logic [WIDTH:0]   w_step_x;
   logic [WIDTH:0]   w_sum_x;
   logic [WIDTH-1:0] w_load_clamped;
   logic             w_step_cyc;
   logic [WIDTH-1:0] w_nxt;
   logic             w_ovf_nxt;
   logic             w_unf_nxt;

   assign w_cnt_x        = {1'b0, r_count};
   assign w_step_x       = {1'b0, step};
   assign w_sum_x        = w_cnt_x + w_step_x;
   assign w_load_clamped = ({1'b0, load_val} > MAX_X) ? MAX_W : load_val;
   assign w_step_cyc     = en && (r_presc == PS_LAST);

   // Next count and flag values for a step cycle.
   always_comb begin
      w_nxt     = r_count;
      w_ovf_nxt = 1'b0;
      w_unf_nxt = 1'b0;
      if (up_down) begin
         if (w_sum_x <= MAX_X) begin
            w_nxt = WIDTH'(w_sum_x);
         end else if (SATURATE != 0) begin
            w_nxt     = MAX_W;
            // Already pinned at the top: no new crossing to report.
            w_ovf_nxt = (r_count != MAX_W);
         end else begin
            w_nxt     = WIDTH'(w_sum_x - MOD_X);
            w_ovf_nxt = 1'b1;
         end
      end else begin
         if (w_step_x <= w_cnt_x) begin
            w_nxt = WIDTH'(w_cnt_x - w_step_x);
         end else if (SATURATE != 0) begin
            w_nxt     = '0;
            w_unf_nxt = (r_count != '0);
         end else begin
            // count + modulus - step stays within WIDTH+1 bits and below the modulus.
            w_nxt     = WIDTH'(w_cnt_x + MOD_X - w_step_x);
            w_unf_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_presc <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (load) begin
         r_count <= w_load_clamped;
         r_presc <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (w_step_cyc) begin
         r_count <= w_nxt;
         r_presc <= '0;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
      end else begin
         if (en) begin
            r_presc <= r_presc + PS_ONE;
         end
         // Flags are single-cycle pulses; any non-step cycle clears them.
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end
   end

   assign count  = r_count;
   assign at_max = (r_count == MAX_W);
   assign at_min = (r_count == '0);
   assign ovf    = r_ovf;
   assign unf    = r_unf;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: five differently configured instances, directed
// scenarios plus constrained-random traffic, checked against a behavioural model.
module tb_param_updown_counter;

   localparam int NI = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s [NI];
   logic       en_s  [NI];
   logic       ud_s  [NI];
   logic       ld_s  [NI];
   logic [7:0] st_s  [NI];
   logic [7:0] lv_s  [NI];

   logic [3:0] c0, c4;
   logic [7:0] c1, c2, c3;
   logic am0, an0, ov0, un0;
   logic am1, an1, ov1, un1;
   logic am2, an2, ov2, un2;
   logic am3, an3, ov3, un3;
   logic am4, an4, ov4, un4;

   // 0: decade wrap      1: 8-bit saturate    2: mod-100 wrap
   // 3: 8-bit wrap /3    4: decade saturate /4
   param_updown_counter #(.WIDTH(4), .MAX_VAL(9),   .SATURATE(0), .PRESCALE(1)) u0 (
      .clk(clk), .reset(rst_s[0]), .en(en_s[0]), .up_down(ud_s[0]), .step(st_s[0][3:0]),
      .load(ld_s[0]), .load_val(lv_s[0][3:0]), .count(c0), .at_max(am0), .at_min(an0),
      .ovf(ov0), .unf(un0));
   param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1), .PRESCALE(1)) u1 (
      .clk(clk), .reset(rst_s[1]), .en(en_s[1]), .up_down(ud_s[1]), .step(st_s[1]),
      .load(ld_s[1]), .load_val(lv_s[1]), .count(c1), .at_max(am1), .at_min(an1),
      .ovf(ov1), .unf(un1));
   param_updown_counter #(.WIDTH(8), .MAX_VAL(99),  .SATURATE(0), .PRESCALE(1)) u2 (
      .clk(clk), .reset(rst_s[2]), .en(en_s[2]), .up_down(ud_s[2]), .step(st_s[2]),
      .load(ld_s[2]), .load_val(lv_s[2]), .count(c2), .at_max(am2), .at_min(an2),
      .ovf(ov2), .unf(un2));
   param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0), .PRESCALE(3)) u3 (
      .clk(clk), .reset(rst_s[3]), .en(en_s[3]), .up_down(ud_s[3]), .step(st_s[3]),
      .load(ld_s[3]), .load_val(lv_s[3]), .count(c3), .at_max(am3), .at_min(an3),
      .ovf(ov3), .unf(un3));
   param_updown_counter #(.WIDTH(4), .MAX_VAL(9),   .SATURATE(1), .PRESCALE(4)) u4 (
      .clk(clk), .reset(rst_s[4]), .en(en_s[4]), .up_down(ud_s[4]), .step(st_s[4][3:0]),
      .load(ld_s[4]), .load_val(lv_s[4][3:0]), .count(c4), .at_max(am4), .at_min(an4),
      .ovf(ov4), .unf(un4));

   function automatic int p_max(int idx);
      case (idx)
         0, 4:    return 9;
         2:       return 99;
         default: return 255;
      endcase
   endfunction
   function automatic int p_sat(int idx);
      return (idx == 1 || idx == 4) ? 1 : 0;
   endfunction
   function automatic int p_ps(int idx);
      case (idx)
         3:       return 3;
         4:       return 4;
         default: return 1;
      endcase
   endfunction
   function automatic int p_w(int idx);
      return (idx == 0 || idx == 4) ? 4 : 8;
   endfunction

   typedef struct {
      int cnt;
      bit ovf;
      bit unf;
      bit amax;
      bit amin;
   } res_t;

   typedef struct {
      int    idx;
      string tag;
      res_t  r;
   } exp_t;

   exp_t sb[$];
   int   m_cnt [NI];
   int   m_ps  [NI];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check_val(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic res_t obs(int idx);
      res_t r;
      case (idx)
         0:       r = '{int'(c0), ov0, un0, am0, an0};
         1:       r = '{int'(c1), ov1, un1, am1, an1};
         2:       r = '{int'(c2), ov2, un2, am2, an2};
         3:       r = '{int'(c3), ov3, un3, am3, an3};
         default: r = '{int'(c4), ov4, un4, am4, an4};
      endcase
      return r;
   endfunction

   // Behavioural reference: one clock of the counter, written from the block description.
   function automatic res_t model(int idx, bit rst, bit en, bit ud, int st, bit ld, int lv);
      res_t e;
      int   mx;
      int   s;
      mx    = p_max(idx);
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (rst) begin
         m_cnt[idx] = 0;
         m_ps[idx]  = 0;
      end else if (ld) begin
         m_cnt[idx] = (lv > mx) ? mx : lv;
         m_ps[idx]  = 0;
      end else if (en) begin
         if (m_ps[idx] == p_ps(idx) - 1) begin
            m_ps[idx] = 0;
            if (ud) begin
               s = m_cnt[idx] + st;
               if (s <= mx) m_cnt[idx] = s;
               else if (p_sat(idx) != 0) begin
                  e.ovf      = (m_cnt[idx] != mx);
                  m_cnt[idx] = mx;
               end else begin
                  m_cnt[idx] = s - (mx + 1);
                  e.ovf      = 1'b1;
               end
            end else begin
               if (st <= m_cnt[idx]) m_cnt[idx] = m_cnt[idx] - st;
               else if (p_sat(idx) != 0) begin
                  e.unf      = (m_cnt[idx] != 0);
                  m_cnt[idx] = 0;
               end else begin
                  m_cnt[idx] = m_cnt[idx] + (mx + 1) - st;
                  e.unf      = 1'b1;
               end
            end
         end else begin
            m_ps[idx] = m_ps[idx] + 1;
         end
      end
      e.cnt  = m_cnt[idx];
      e.amax = (m_cnt[idx] == mx);
      e.amin = (m_cnt[idx] == 0);
      return e;
   endfunction

   task automatic compare_next();
      exp_t x;
      res_t o;
      x = sb.pop_front();
      o = obs(x.idx);
      check_val({x.tag, ".cnt"},  o.cnt,       x.r.cnt);
      check_val({x.tag, ".ovf"},  int'(o.ovf),  int'(x.r.ovf));
      check_val({x.tag, ".unf"},  int'(o.unf),  int'(x.r.unf));
      check_val({x.tag, ".amax"}, int'(o.amax), int'(x.r.amax));
      check_val({x.tag, ".amin"}, int'(o.amin), int'(x.r.amin));
   endtask

   // One clock on instance idx; the other instances idle (count and prescaler hold).
   task automatic drive(input int idx, input bit rst, input bit en, input bit ud,
                        input int st, input bit ld, input int lv, input string tag);
      exp_t x;
      assert (st <= p_max(idx)) else $fatal(1, "FAIL illegal_step: got %0d limit %0d", st, p_max(idx));
      rst_s[idx] = rst;
      en_s[idx]  = en;
      ud_s[idx]  = ud;
      ld_s[idx]  = ld;
      st_s[idx]  = 8'(st);
      lv_s[idx]  = 8'(lv);
      x.idx = idx;
      x.tag = $sformatf("%s[%0d]", tag, idx);
      x.r   = model(idx, rst, en, ud, st, ld, lv);
      sb.push_back(x);
      @(posedge clk);
      #1;
      compare_next();
      rst_s[idx] = 1'b0;
      en_s[idx]  = 1'b0;
      ld_s[idx]  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst_s[i] = 1'b1; en_s[i] = 1'b0; ud_s[i] = 1'b0; ld_s[i] = 1'b0;
         st_s[i]  = 8'd0; lv_s[i] = 8'd0; m_cnt[i] = 0; m_ps[i] = 0;
      end
      for (int i = 0; i < NI; i++) drive(i, 1, 0, 0, 0, 0, 0, "reset");

      // Decade counter: wrap up through 9 -> 0.
      for (int k = 1; k <= 10; k++) begin
         drive(0, 0, 1, 1, 1, 0, 0, "a_up");
         if (k == 9) check_val("a_atmax_at9", int'(am0), 1);
      end
      check_val("a_wrap_cnt", int'(c0), 0);
      check_val("a_wrap_ovf", int'(ov0), 1);
      // Wrap down with a large step.
      drive(0, 0, 0, 0, 0, 1, 2, "a_ld");
      drive(0, 0, 1, 0, 5, 0, 0, "a_dn");
      check_val("a_wdn_cnt", int'(c0), 7);
      check_val("a_wdn_unf", int'(un0), 1);
      drive(0, 0, 1, 0, 5, 0, 0, "a_dn");
      check_val("a_dn2_cnt", int'(c0), 2);
      check_val("a_dn2_unf", int'(un0), 0);

      // Saturating 8-bit counter.
      drive(1, 0, 0, 0, 0, 1, 250, "b_ld");
      drive(1, 0, 1, 1, 10, 0, 0, "b_up");
      check_val("b_sat_cnt", int'(c1), 255);
      check_val("b_sat_ovf", int'(ov1), 1);
      drive(1, 0, 1, 1, 10, 0, 0, "b_up");
      check_val("b_hold_cnt", int'(c1), 255);
      check_val("b_hold_ovf", int'(ov1), 0);
      drive(1, 0, 0, 0, 0, 1, 3, "b_ld");
      drive(1, 0, 1, 0, 4, 0, 0, "b_dn");
      check_val("b_satdn_cnt", int'(c1), 0);
      check_val("b_satdn_unf", int'(un1), 1);
      drive(1, 0, 1, 0, 4, 0, 0, "b_dn");
      check_val("b_floor_unf", int'(un1), 0);
      // Load beats enable in the same cycle.
      drive(1, 0, 1, 1, 1, 1, 200, "b_prio");
      check_val("b_prio_cnt", int'(c1), 200);

      // Load clamp on a mod-100 counter, then wrap.
      drive(2, 0, 0, 0, 0, 1, 200, "c_clamp");
      check_val("c_clamp_cnt", int'(c2), 99);
      check_val("c_clamp_amax", int'(am2), 1);
      drive(2, 0, 0, 0, 0, 1, 95, "c_ld");
      drive(2, 0, 1, 1, 10, 0, 0, "c_up");
      check_val("c_wrap_cnt", int'(c2), 5);

      // Prescale by 3, en dropped on cycles 5 and 6.
      drive(3, 1, 0, 0, 0, 0, 0, "d_rst");
      for (int c = 1; c <= 9; c++) begin
         drive(3, 0, (c == 5 || c == 6) ? 1'b0 : 1'b1, 1, 1, 0, 0, "d_ps");
         if (c == 2) check_val("d_c2_cnt", int'(c3), 0);
         if (c == 3) check_val("d_c3_cnt", int'(c3), 1);
         if (c == 7) check_val("d_c7_cnt", int'(c3), 1);
         if (c == 8) check_val("d_c8_cnt", int'(c3), 2);
      end
      // Load mid-prescale restarts the prescaler.
      drive(3, 1, 0, 0, 0, 0, 0, "d_rst");
      for (int c = 1; c <= 4; c++) drive(3, 0, 1, 1, 1, 0, 0, "d_pre");
      drive(3, 0, 1, 1, 1, 1, 10, "d_ld");
      drive(3, 0, 1, 1, 1, 0, 0, "d_post");
      drive(3, 0, 1, 1, 1, 0, 0, "d_post");
      check_val("d_ld_c7_cnt", int'(c3), 10);
      drive(3, 0, 1, 1, 1, 0, 0, "d_post");
      check_val("d_ld_c8_cnt", int'(c3), 11);

      // Reset mid-prescale wins over load and en.
      drive(4, 0, 0, 0, 0, 1, 7, "e_ld");
      drive(4, 0, 1, 1, 1, 0, 0, "e_en");
      drive(4, 0, 1, 1, 1, 0, 0, "e_en");
      check_val("e_pre_cnt", int'(c4), 7);
      drive(4, 1, 1, 1, 1, 1, 5, "e_rst");
      check_val("e_rst_cnt", int'(c4), 0);
      check_val("e_rst_amin", int'(an4), 1);
      for (int c = 1; c <= 3; c++) drive(4, 0, 1, 1, 1, 0, 0, "e_en");
      check_val("e_c3_cnt", int'(c4), 0);
      drive(4, 0, 1, 1, 1, 0, 0, "e_en");
      check_val("e_c4_cnt", int'(c4), 1);

      // Constrained-random traffic on every configuration.
      for (int i = 0; i < NI; i++) begin
         for (int n = 0; n < 300; n++) begin
            int  mx;
            int  st;
            int  lv;
            bit  rst;
            bit  ld;
            bit  en;
            mx  = p_max(i);
            rst = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, mx))
                                               : int'($urandom_range(0, 2));
            lv  = int'($urandom_range(0, (1 << p_w(i)) - 1));
            drive(i, rst, en, 1'($urandom_range(0, 1)), st, ld, lv, "rnd");
         end
      end

      check_val("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised up/down counter for the general sequential-block library.
- Features: configurable width and modulus, wrap or saturate mode, variable step, synchronous parallel load, count enable with a built-in prescaler, and boundary/overflow flags.
- Replaces fixed-width 8-bit up/down counters; also serves as a decade/modulo-N counter and event rate divider.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1, highest count value (1..2**WIDTH-1); count range 0..MAX_VAL, modulus MAX_VAL+1.
- SATURATE, 0, 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.
- PRESCALE, 1, counter steps once per PRESCALE enabled cycles (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; advances prescaler.
- up_down  in  1  1 = count up, 0 = count down; sampled on step cycles.
- step  in  WIDTH  increment/decrement magnitude; legal range 0..MAX_VAL.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value loaded when load=1.
- count  out  WIDTH  current count (registered).
- at_max  out  1  combinational: count == MAX_VAL.
- at_min  out  1  combinational: count == 0.
- ovf  out  1  registered one-cycle pulse: up step crossed MAX_VAL.
- unf  out  1  registered one-cycle pulse: down step crossed 0.

Behaviour:
- Reset: count=0, prescaler=0, ovf=0, unf=0, so at_min=1 and at_max=0. Reset has priority over all other inputs and aborts any pending prescale.
- Priority: reset > load > en.
- Load:
  - count <= min(load_val, MAX_VAL).
  - Prescaler cleared to 0; ovf=unf=0 in the following cycle.
- Prescaler:
  - Internal counter 0..PRESCALE-1, increments on each cycle with en=1 and no load.
  - Step cycle = en=1 while prescaler == PRESCALE-1; the prescaler returns to 0 on that cycle.
  - With PRESCALE=1, every en cycle is a step cycle.
  - en=0 holds both the prescaler and count.
- Step arithmetic: performed in WIDTH+1 bits, so no intermediate overflow.
  - Up: sum = count + step.
    - sum <= MAX_VAL: count <= sum.
    - Else, wrap mode: count <= sum - (MAX_VAL+1), ovf pulses.
    - Else, saturate mode: count <= MAX_VAL; ovf pulses only if count was not already MAX_VAL.
  - Down:
    - step <= count: count <= count - step.
    - Else, wrap mode: count <= count + (MAX_VAL+1) - step, unf pulses.
    - Else, saturate mode: count <= 0; unf pulses only if count was not already 0.
- step=0: count unchanged, no flags, prescaler still advances.
- Flag timing:
  - ovf/unf assert in the same cycle the new count becomes visible (1-cycle latency from the step edge).
  - They are cleared on every non-step cycle; never both high.
- Changing up_down on a non-step cycle has no effect.
- step > MAX_VAL is illegal. The bench asserts it never occurs; the RTL result is unspecified.
- Non-power-of-2 MAX_VAL: count values above MAX_VAL are never reachable.

Test Plan:
- Reset and wrap-up: WIDTH=4, MAX_VAL=9, SATURATE=0, PRESCALE=1, reset then en=1, up_down=1, step=1 for 10 cycles -> count 1..9, then 0 on the 10th step; ovf=1 exactly in the cycle count becomes 0; at_max=1 while count=9.
- Wrap-down with large step: same config, load 2 then down step=5 -> count=7, unf=1 for one cycle; next down step=5 -> count=2, unf=0.
- Saturate: WIDTH=8, MAX_VAL=255, SATURATE=1, load 250, up step=10 -> count=255, ovf=1; repeat step -> count stays 255, ovf=0. Load 3, down step=4 -> count=0, unf=1.
- Priority: load=1, load_val=200, en=1, up step=1 in the same cycle -> count=200 (no increment). Config MAX_VAL=99: load_val=200 -> count=99.
- Prescaler: PRESCALE=3, en=1, up step=1 -> count increments on cycles 3, 6, 9. Drop en for 2 cycles after cycle 4 -> next increment at cycle 8. Load at cycle 5 -> prescaler restarts and the next step is 3 enabled cycles later.
- Reset mid-operation: PRESCALE=4, count=7, prescaler=2, assert reset with en=1 and load=1 -> next cycle count=0, ovf=unf=0, at_min=1; first step occurs 4 enabled cycles after reset deasserts.
